spi_xfer_sequencer: RTL and testbench

Master-side transfer sequencer for the SPI block. It sits between the APB register/control logic and the SCLK baud generator. It accepts one 8-bit word per request and drives slave-select low for the duration of the transfer. Using the generator's pre-edge strobes, it shifts the word out on MOSI and captures MISO, then returns the received byte with a one-cycle valid pulse.

---
 rtl/spi_xfer_sequencer.sv | 133 +++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_sequencer.sv
// SPI master transfer sequencer: shifts one DATA_W word out on MOSI while capturing MISO,
// using the baud generator's pre-edge strobes; result is presented with a one-cycle valid pulse.
module spi_xfer_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              mstr_i,
  input  logic              spe_i,
  input  logic [1:0]        spi_mode_i,
  input  logic              spiswai_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic              send_data_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              mosi_send_sclk_i,
  input  logic              mosi_send_sclk0_i,
  input  logic              miso_recieve_sclk_i,
  input  logic              miso_recieve_sclk0_i,
  input  logic              miso_i,
  output logic              ss_o,
  output logic              mosi_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              tx_ready_o,
  output logic              busy_o,
  output logic              abort_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_XFER = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]        state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  tx_idx;
  logic              lsb_q;
  logic              sel;
  logic              shift_stb;
  logic              sample_stb;
  logic              enabled;

  // Modes 1 and 2 use the alternate strobe pair from the baud generator.
  assign sel        = cpol_i ^ cpha_i;
  assign shift_stb  = sel ? mosi_send_sclk0_i    : mosi_send_sclk_i;
  assign sample_stb = sel ? miso_recieve_sclk0_i : miso_recieve_sclk_i;

  assign enabled = mstr_i & spe_i &
                   ((spi_mode_i == 2'b00) | ((spi_mode_i == 2'b01) & ~spiswai_i));

  assign tx_idx  = lsb_q ? bit_cnt[IDX_W-1:0] : (LAST_IDX - bit_cnt[IDX_W-1:0]);
  assign rx_next = lsb_q ? {miso_i, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso_i};

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state      <= ST_IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      lsb_q      <= 1'b0;
      ss_o       <= 1'b1;
      mosi_o     <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b1;
      busy_o     <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      abort_o    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (send_data_i && enabled) begin
            state      <= ST_XFER;
            tx_sr      <= tx_data_i;
            lsb_q      <= lsbfe_i;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            mosi_o     <= lsbfe_i ? tx_data_i[0] : tx_data_i[DATA_W-1];
            ss_o       <= 1'b0;
            busy_o     <= 1'b1;
            tx_ready_o <= 1'b0;
          end
        end
        ST_XFER: begin
          if (!enabled) begin
            state      <= ST_IDLE;
            abort_o    <= 1'b1;
            ss_o       <= 1'b1;
            busy_o     <= 1'b0;
            tx_ready_o <= 1'b1;
          end else begin
            if (sample_stb) begin
              rx_sr   <= rx_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_CNT) begin
                state      <= ST_DONE;
                rx_data_o  <= rx_next;
                rx_valid_o <= 1'b1;
                ss_o       <= 1'b1;
                busy_o     <= 1'b0;
              end
            end
            // A coincident shift still uses the pre-increment bit index.
            if (shift_stb) begin
              mosi_o <= tx_sr[tx_idx];
            end
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          tx_ready_o <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          ss_o       <= 1'b1;
          busy_o     <= 1'b0;
          tx_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer with a behavioural baud generator and slave model.
module tb_spi_xfer_sequencer;
  logic       PCLK = 1'b0;
  logic       PRESET_n;
  logic       mstr_i, spe_i, spiswai_i, cpol_i, cpha_i, lsbfe_i, send_data_i;
  logic [1:0] spi_mode_i;
  logic [7:0] tx_data_i;
  logic       mosi_send_sclk_i, mosi_send_sclk0_i, miso_recieve_sclk_i, miso_recieve_sclk0_i;
  logic       miso_i;
  logic       ss_o, mosi_o, rx_valid_o, tx_ready_o, busy_o, abort_o;
  logic [7:0] rx_data_o;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] last_rx;

  always #5 PCLK = ~PCLK;

  spi_xfer_sequencer #(.DATA_W(8)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .mstr_i(mstr_i), .spe_i(spe_i),
    .spi_mode_i(spi_mode_i), .spiswai_i(spiswai_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .lsbfe_i(lsbfe_i), .send_data_i(send_data_i), .tx_data_i(tx_data_i),
    .mosi_send_sclk_i(mosi_send_sclk_i), .mosi_send_sclk0_i(mosi_send_sclk0_i),
    .miso_recieve_sclk_i(miso_recieve_sclk_i), .miso_recieve_sclk0_i(miso_recieve_sclk0_i),
    .miso_i(miso_i), .ss_o(ss_o), .mosi_o(mosi_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .tx_ready_o(tx_ready_o), .busy_o(busy_o), .abort_o(abort_o)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Selected pair carries the real pattern; the other pair is held high to expose wrong selection.
  task automatic drive_strobes(input bit sh, input bit sa, input bit other);
    if (cpol_i ^ cpha_i) begin
      mosi_send_sclk0_i = sh;  miso_recieve_sclk0_i = sa;
      mosi_send_sclk_i  = other; miso_recieve_sclk_i = other;
    end else begin
      mosi_send_sclk_i  = sh;  miso_recieve_sclk_i = sa;
      mosi_send_sclk0_i = other; miso_recieve_sclk0_i = other;
    end
  endtask

  always @(negedge PCLK) begin
    if (PRESET_n && rx_valid_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rx_valid: got rx_valid_o=1 data %h, expected no valid", rx_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        chk8("rx_data", rx_data_o, mon_exp);
        chk1("ss_high_at_valid", ss_o, 1'b1);
      end
    end
  end

  task automatic wait_drain();
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge PCLK);
    chk1("scoreboard_drained", exp_q.size() == 0, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk1({tag, "_ss"}, ss_o, 1'b1);
    chk1({tag, "_mosi"}, mosi_o, 1'b0);
    chk8({tag, "_rx_data"}, rx_data_o, 8'h00);
    chk1({tag, "_rx_valid"}, rx_valid_o, 1'b0);
    chk1({tag, "_tx_ready"}, tx_ready_o, 1'b1);
    chk1({tag, "_busy"}, busy_o, 1'b0);
    chk1({tag, "_abort"}, abort_o, 1'b0);
  endtask

  // Issues one transfer, emulating a divisor-4 baud generator: shift at phase 1, sample at phase 3.
  task automatic xfer(input logic [7:0] tx, input bit lsb, input bit cp, input bit ch,
                      input bit lp, input logic [7:0] sw, input int abort_at,
                      input int rst_at, input bit busy_req);
    int         low_cnt;
    logic [7:0] exp_rx;
    cpol_i = cp; cpha_i = ch; lsbfe_i = lsb; tx_data_i = tx; send_data_i = 1'b1;
    exp_rx = lp ? tx : sw;
    if (abort_at < 0 && rst_at < 0) exp_q.push_back(exp_rx);
    @(negedge PCLK);
    send_data_i = 1'b0;
    tx_data_i   = 8'($urandom);
    lsbfe_i     = ~lsb;
    chk1("ss_fall", ss_o, 1'b0);
    chk1("busy_in_xfer", busy_o, 1'b1);
    chk1("tx_ready_in_xfer", tx_ready_o, 1'b0);
    low_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      for (int ph = 0; ph < 4; ph++) begin
        if (ss_o == 1'b0) low_cnt++;
        if (i == abort_at && ph == 0) begin
          spe_i = 1'b0;
          drive_strobes(1'b0, 1'b1, 1'b1);
          @(negedge PCLK);
          spe_i = 1'b1;
          drive_strobes(1'b0, 1'b0, 1'b0);
          chk1("abort_pulse", abort_o, 1'b1);
          chk1("abort_ss_high", ss_o, 1'b1);
          chk1("abort_busy", busy_o, 1'b0);
          chk8("abort_rx_kept", rx_data_o, last_rx);
          @(negedge PCLK);
          chk1("abort_one_cycle", abort_o, 1'b0);
          chk1("abort_tx_ready", tx_ready_o, 1'b1);
          return;
        end
        if (i == rst_at && ph == 0) begin
          #2 PRESET_n = 1'b0;
          #1 check_reset_vals("async_rst");
          @(negedge PCLK);
          PRESET_n = 1'b1;
          drive_strobes(1'b0, 1'b0, 1'b0);
          last_rx = 8'h00;
          @(negedge PCLK);
          chk1("post_rst_no_abort", abort_o, 1'b0);
          return;
        end
        send_data_i = (busy_req && i == 2 && ph == 0);
        if (send_data_i) tx_data_i = ~tx;
        drive_strobes(ph == 1, ph == 3, 1'b1);
        if (ph == 3) begin
          chk1($sformatf("mosi_bit%0d", i), mosi_o, lsb ? tx[i] : tx[7-i]);
          miso_i = lp ? mosi_o : (lsb ? sw[i] : sw[7-i]);
        end
        @(negedge PCLK);
      end
    end
    drive_strobes(1'b0, 1'b0, 1'b0);
    chk1("ss_rise_after_last_sample", ss_o, 1'b1);
    chk1("tx_ready_low_in_done", tx_ready_o, 1'b0);
    chk1("ss_low_len_32pm1", low_cnt >= 31 && low_cnt <= 33, 1'b1);
    @(negedge PCLK);
    chk1("rx_valid_single_pulse", rx_valid_o, 1'b0);
    chk1("tx_ready_after_done", tx_ready_o, 1'b1);
    last_rx = exp_rx;
    wait_drain();
  endtask

  initial begin
    PRESET_n = 1'b0; mstr_i = 1'b1; spe_i = 1'b1; spi_mode_i = 2'b00; spiswai_i = 1'b0;
    cpol_i = 1'b0; cpha_i = 1'b0; lsbfe_i = 1'b0; send_data_i = 1'b0; tx_data_i = 8'h00;
    miso_i = 1'b0; last_rx = 8'h00;
    drive_strobes(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge PCLK);
    check_reset_vals("reset");
    PRESET_n = 1'b1;
    @(negedge PCLK);

    // Mode 0 loopback, MSB first.
    xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, -1, -1, 1'b0);
    // Mode 3, LSB first, slave returns 0x80.
    xfer(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, -1, -1, 1'b0);
    // All four clock modes.
    for (int m = 0; m < 4; m++)
      xfer(8'($urandom), 1'($urandom_range(0, 1)), 1'(m >> 1), 1'(m & 1),
           1'(m & 1), 8'($urandom), -1, -1, 1'b0);
    // Abort after three bits.
    xfer(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3, 3, -1, 1'b0);

    // Wait mode with spiswai set: request ignored.
    spi_mode_i = 2'b01; spiswai_i = 1'b1; tx_data_i = 8'h77; send_data_i = 1'b1;
    @(negedge PCLK);
    send_data_i = 1'b0;
    chk1("waitstop_ss", ss_o, 1'b1);
    chk1("waitstop_ready", tx_ready_o, 1'b1);
    @(negedge PCLK);
    chk1("waitstop_busy", busy_o, 1'b0);
    // Wait mode without spiswai still runs.
    spiswai_i = 1'b0;
    xfer(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 8'h2D, -1, -1, 1'b0);
    spi_mode_i = 2'b00;

    // Request while busy is ignored.
    xfer(8'hC6, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, -1, -1, 1'b1);
    // Reset mid-transfer, then a clean 0x3C transfer.
    xfer(8'hE7, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, -1, 4, 1'b0);
    xfer(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, -1, -1, 1'b0);

    for (int r = 0; r < 10; r++)
      xfer(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), -1, -1,
           1'($urandom_range(0, 1)));

    repeat (3) @(negedge PCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
